pcie_packet_identifier: RTL and testbench

Gen1/Gen2 (8b/10b) physical-layer packet framing identifier for a 512-bit receive datapath. It sits after lane deskew and ordered-set removal. Each beat it scans up to 64 symbol bytes, tracks TLP/DLLP framing across beats, and outputs registered data with per-byte start, end, nullify and valid flags for the data-link layer.

---
 rtl/pkt_id_pkg.sv | 13 +
 rtl/pkt_id_sym_decode.sv | 16 +
 rtl/pcie_packet_identifier.sv | 102 ++++++++++
 tb/tb_pcie_packet_identifier.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pkt_id_pkg.sv
// pkt_id_pkg: K-code constants, scan states, gen encodings and lane-to-byte mask helper.
package pkt_id_pkg;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [2:0] GEN1 = 3'b000;
    localparam logic [2:0] GEN2 = 3'b001;
    typedef enum logic [1:0] {IDLE, IN_TLP, IN_DLP} state_t;
    function automatic logic [63:0] lanes_to_mask(input logic [4:0] lanes);
        return lanes >= 5'd16 ? {64{1'b1}} : (64'd1 << {lanes, 2'b00}) - 64'd1;
    endfunction
endpackage

// File: rtl/pkt_id_sym_decode.sv
// pkt_id_sym_decode: classifies one symbol byte as STP/SDP/END/EDB when it is a K symbol.
module pkt_id_sym_decode
    import pkt_id_pkg::*;
(
    input  logic [7:0] sym,
    input  logic       k,
    output logic       is_stp,
    output logic       is_sdp,
    output logic       is_end,
    output logic       is_edb
);
    assign is_stp = k && sym == K_STP;
    assign is_sdp = k && sym == K_SDP;
    assign is_end = k && sym == K_END;
    assign is_edb = k && sym == K_EDB;
endmodule

// File: rtl/pcie_packet_identifier.sv
// pcie_packet_identifier: per-byte TLP/DLLP framing flags, 1-cycle latency; PKT_ID_DATA_MASK_EN zeroes non-packet data bytes.
module pcie_packet_identifier
    import pkt_id_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] data_in,
    input  logic [63:0]  DK,
    input  logic         valid_pd,
    input  logic         linkup,
    input  logic [2:0]   gen,
    input  logic [4:0]   numberOfDetectedLanes,
    output logic [511:0] data_out,
    output logic [63:0]  pl_valid,
    output logic [63:0]  pl_tlpstart,
    output logic [63:0]  pl_tlpend,
    output logic [63:0]  pl_tlpedb,
    output logic [63:0]  pl_dlpstart,
    output logic [63:0]  pl_dlpend,
    output logic         w
);
    state_t state, next_state, st;
    logic [63:0] stp, sdp, endk, edb, act;
    logic [63:0] valid_n, tstart_n, tend_n, tedb_n, dstart_n, dend_n;
    logic [511:0] data_n;
    logic link_ok;
    for (genvar g = 0; g < 64; g++) begin : g_dec
        pkt_id_sym_decode u_dec (
            .sym    (data_in[8*g +: 8]),
            .k      (DK[g]),
            .is_stp (stp[g]),
            .is_sdp (sdp[g]),
            .is_end (endk[g]),
            .is_edb (edb[g])
        );
    end
`ifdef PKT_ID_DATA_MASK_EN
    for (genvar g = 0; g < 64; g++) begin : g_mask
        assign data_n[8*g +: 8] = valid_n[g] ? data_in[8*g +: 8] : 8'h00;
    end
`else
    assign data_n = data_in;
`endif
    assign act = lanes_to_mask(numberOfDetectedLanes);
    assign link_ok = linkup && (gen == GEN1 || gen == GEN2);
    // Bytes are walked in order so several packets can open and close within one beat.
    always_comb begin
        st = state;
        valid_n = '0;
        tstart_n = '0;
        tend_n = '0;
        tedb_n = '0;
        dstart_n = '0;
        dend_n = '0;
        for (int i = 0; i < 64; i++) begin
            if (act[i]) begin
                if (stp[i]) begin
                    tstart_n[i] = 1'b1;
                    valid_n[i] = 1'b1;
                    st = IN_TLP;
                end else if (sdp[i]) begin
                    dstart_n[i] = 1'b1;
                    valid_n[i] = 1'b1;
                    st = IN_DLP;
                end else if (st == IN_TLP) begin
                    valid_n[i] = 1'b1;
                    tend_n[i] = endk[i];
                    tedb_n[i] = edb[i];
                    st = endk[i] || edb[i] ? IDLE : IN_TLP;
                end else if (st == IN_DLP) begin
                    valid_n[i] = 1'b1;
                    dend_n[i] = endk[i];
                    st = endk[i] ? IDLE : IN_DLP;
                end
            end
        end
        next_state = st;
    end
    always_ff @(posedge clk) begin
        if (!rst || !link_ok || !valid_pd) begin
            state <= !rst || !link_ok ? IDLE : state;
            data_out <= '0;
            pl_valid <= '0;
            pl_tlpstart <= '0;
            pl_tlpend <= '0;
            pl_tlpedb <= '0;
            pl_dlpstart <= '0;
            pl_dlpend <= '0;
            w <= 1'b0;
        end else begin
            state <= next_state;
            data_out <= data_n;
            pl_valid <= valid_n;
            pl_tlpstart <= tstart_n;
            pl_tlpend <= tend_n;
            pl_tlpedb <= tedb_n;
            pl_dlpstart <= dstart_n;
            pl_dlpend <= dend_n;
            w <= next_state != IDLE;
        end
    end
endmodule

// File: tb/tb_pcie_packet_identifier.sv
// tb_pcie_packet_identifier: directed framing vectors with hand-computed flag expectations.
module tb_pcie_packet_identifier;
    logic clk = 1'b0;
    logic rst;
    logic [511:0] data_in;
    logic [63:0] DK;
    logic valid_pd, linkup;
    logic [2:0] gen;
    logic [4:0] numberOfDetectedLanes;
    logic [511:0] data_out;
    logic [63:0] pl_valid, pl_tlpstart, pl_tlpend, pl_tlpedb, pl_dlpstart, pl_dlpend;
    logic w;
    int n_checks = 0;
    int n_fail = 0;
    logic [511:0] exp_d;
    pcie_packet_identifier dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_in               (data_in),
        .DK                    (DK),
        .valid_pd              (valid_pd),
        .linkup                (linkup),
        .gen                   (gen),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .data_out              (data_out),
        .pl_valid              (pl_valid),
        .pl_tlpstart           (pl_tlpstart),
        .pl_tlpend             (pl_tlpend),
        .pl_tlpedb             (pl_tlpedb),
        .pl_dlpstart           (pl_dlpstart),
        .pl_dlpend             (pl_dlpend),
        .w                     (w)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic clr();
        data_in = '0;
        DK = '0;
    endtask
    task automatic put(input int i, input logic [7:0] v, input logic k);
        data_in[8*i +: 8] = v;
        DK[i] = k;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b0;
        valid_pd = 1'b1;
        linkup = 1'b1;
        gen = 3'b000;
        numberOfDetectedLanes = 5'd8;
        clr();
        put(0, 8'hFB, 1'b1);
        step();
        step();
        check("rst_valid", pl_valid, 0);
        check("rst_tstart", pl_tlpstart, 0);
        check("rst_w", w, 0);
        check("rst_data", data_out, 0);
        rst = 1'b1;
        clr();
        step();
        check("idle_valid", pl_valid, 0);
        check("idle_w", w, 0);
        put(0, 8'hFB, 1'b1);
        put(15, 8'hFD, 1'b1);
        put(20, 8'h55, 1'b0);
        exp_d = data_in;
        step();
        check("tlp1_start", pl_tlpstart, 64'h1);
        check("tlp1_end", pl_tlpend, 64'h8000);
        check("tlp1_valid", pl_valid, 64'hFFFF);
        check("tlp1_w", w, 0);
        check("tlp1_data", data_out, exp_d);
        clr();
        put(0, 8'hFB, 1'b1);
        step();
        check("mbA_valid", pl_valid, 64'hFFFF_FFFF);
        check("mbA_w", w, 1);
        clr();
        put(3, 8'hFD, 1'b0);
        put(5, 8'hFB, 1'b0);
        step();
        check("mbB_valid", pl_valid, 64'hFFFF_FFFF);
        check("mbB_end", pl_tlpend, 0);
        check("mbB_w", w, 1);
        clr();
        put(10, 8'hFD, 1'b1);
        step();
        check("mbC_end", pl_tlpend, 64'h400);
        check("mbC_valid", pl_valid, 64'h7FF);
        check("mbC_start", pl_tlpstart, 0);
        check("mbC_w", w, 0);
        clr();
        put(0, 8'h5C, 1'b1);
        put(7, 8'hFD, 1'b1);
        put(8, 8'hFB, 1'b1);
        put(20, 8'hFE, 1'b1);
        step();
        check("mix_dstart", pl_dlpstart, 64'h1);
        check("mix_dend", pl_dlpend, 64'h80);
        check("mix_tstart", pl_tlpstart, 64'h100);
        check("mix_tedb", pl_tlpedb, 64'h10_0000);
        check("mix_tend", pl_tlpend, 0);
        check("mix_valid", pl_valid, 64'h1F_FFFF);
        check("mix_w", w, 0);
        clr();
        put(0, 8'h5C, 1'b1);
        put(3, 8'hFE, 1'b1);
        put(5, 8'hFD, 1'b1);
        step();
        check("dedb_tedb", pl_tlpedb, 0);
        check("dedb_dend", pl_dlpend, 64'h20);
        check("dedb_valid", pl_valid, 64'h3F);
        clr();
        put(0, 8'hFB, 1'b1);
        put(4, 8'hFB, 1'b1);
        put(9, 8'hFD, 1'b1);
        step();
        check("restart_start", pl_tlpstart, 64'h11);
        check("restart_end", pl_tlpend, 64'h200);
        check("restart_valid", pl_valid, 64'h3FF);
        numberOfDetectedLanes = 5'd16;
        gen = 3'b001;
        clr();
        put(0, 8'hFB, 1'b1);
        put(63, 8'hFD, 1'b1);
        step();
        check("x16_valid", pl_valid, {64{1'b1}});
        check("x16_end", pl_tlpend, 64'h8000_0000_0000_0000);
        numberOfDetectedLanes = 5'd1;
        clr();
        put(0, 8'hFB, 1'b1);
        put(6, 8'hFD, 1'b1);
        step();
        check("x1_valid", pl_valid, 64'hF);
        check("x1_end", pl_tlpend, 0);
        check("x1_w", w, 1);
        valid_pd = 1'b0;
        clr();
        put(1, 8'hAA, 1'b0);
        step();
        check("vpd0_valid", pl_valid, 0);
        check("vpd0_w", w, 0);
        check("vpd0_data", data_out, 0);
        valid_pd = 1'b1;
        step();
        check("resume_valid", pl_valid, 64'hF);
        check("resume_w", w, 1);
        linkup = 1'b0;
        step();
        check("lk0_valid", pl_valid, 0);
        check("lk0_data", data_out, 0);
        linkup = 1'b1;
        step();
        check("lk1_valid", pl_valid, 0);
        check("lk1_w", w, 0);
        numberOfDetectedLanes = 5'd8;
        clr();
        put(0, 8'hFB, 1'b1);
        step();
        gen = 3'b010;
        clr();
        step();
        check("rsvgen_valid", pl_valid, 0);
        gen = 3'b000;
        step();
        check("rsvgen_clear", pl_valid, 0);
        put(0, 8'hFB, 1'b1);
        step();
        check("rstmid_open", w, 1);
        clr();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("rstmid_valid", pl_valid, 0);
        check("rstmid_w", w, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
